wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 30 +++
 rtl/wb_skid_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared writeback-pipeline constants and types.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int unsigned C_DATA_W     = 32;
    localparam int unsigned C_ADDR_W     = 5;
    localparam int unsigned C_FIFO_DEPTH = 2;
    localparam int unsigned C_PTR_W      = $clog2(C_FIFO_DEPTH);
    localparam int unsigned C_CNT_W      = $clog2(C_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [C_DATA_W-1:0] data;
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] instr;
        logic [C_DATA_W-1:0] pc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_MULT = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_fifo
// Description : Two-entry skid buffer holding deferred ALU writeback results.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_fifo
    import wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  wb_entry_t          i_push_entry,
    input  logic               i_pop,
    output wb_entry_t          o_head,
    output logic [C_CNT_W-1:0] o_count,
    output logic               o_full,
    output logic               o_empty
);

    wb_entry_t          r_mem [C_FIFO_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign o_count   = r_count;
    assign o_full    = (r_count == C_CNT_W'(C_FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];

    // A push into a full buffer is accepted only when the head leaves the same cycle.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter merging multiplier and ALU results onto the
//               single register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic [C_DATA_W-1:0] mult_int_write_data_i,
    input  logic [C_ADDR_W-1:0] mult_write_addr_i,
    input  logic                mult_int_write_enable_i,
    input  logic [C_DATA_W-1:0] mult_instruction_i,
    input  logic [C_DATA_W-1:0] mult_pc_i,
    input  logic [C_DATA_W-1:0] alu_int_write_data_i,
    input  logic [C_ADDR_W-1:0] alu_write_addr_i,
    input  logic                alu_int_write_enable_i,
    input  logic [C_DATA_W-1:0] alu_instruction_i,
    input  logic [C_DATA_W-1:0] alu_pc_i,
    output logic [C_DATA_W-1:0] rf_write_data_o,
    output logic [C_ADDR_W-1:0] rf_write_addr_o,
    output logic                rf_write_enable_o,
    output logic [C_DATA_W-1:0] wb_instruction_o,
    output logic [C_DATA_W-1:0] wb_pc_o,
    output logic                stall_o,
    output logic                overflow_o
);

    wb_src_e            w_src;
    wb_entry_t          w_mult_entry;
    wb_entry_t          w_alu_entry;
    wb_entry_t          w_head;
    wb_entry_t          w_sel;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_alu_defer;
    logic               w_drop;
    logic [C_CNT_W-1:0] w_count;

    logic [C_DATA_W-1:0] r_rf_data;
    logic [C_ADDR_W-1:0] r_rf_addr;
    logic                r_rf_we;
    logic [C_DATA_W-1:0] r_wb_instr;
    logic [C_DATA_W-1:0] r_wb_pc;
    logic                r_overflow;

    assign w_mult_entry = '{data:  mult_int_write_data_i,
                            addr:  mult_write_addr_i,
                            instr: mult_instruction_i,
                            pc:    mult_pc_i};
    assign w_alu_entry  = '{data:  alu_int_write_data_i,
                            addr:  alu_write_addr_i,
                            instr: alu_instruction_i,
                            pc:    alu_pc_i};

    // Buffered ALU results outrank a fresh ALU result to keep program order.
    always_comb begin
        w_src = SRC_IDLE;
        if (mult_int_write_enable_i) begin
            w_src = SRC_MULT;
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
        end else if (alu_int_write_enable_i) begin
            w_src = SRC_ALU;
        end
    end

    always_comb begin
        w_sel = w_head;
        case (w_src)
            SRC_MULT: w_sel = w_mult_entry;
            SRC_ALU:  w_sel = w_alu_entry;
            default:  w_sel = w_head;
        endcase
    end

    assign w_pop       = (w_src == SRC_FIFO);
    assign w_alu_defer = alu_int_write_enable_i && (w_src != SRC_ALU);
    assign w_push      = w_alu_defer && (!w_full || w_pop);
    assign w_drop      = w_alu_defer && w_full && !w_pop;

    wb_skid_fifo u_skid_fifo (
        .clk          (clk_i),
        .rst_n        (rsn_i),
        .i_push       (w_push),
        .i_push_entry (w_alu_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Idle cycles hold the payload; writes to x0 retire without a strobe.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_rf_data  <= '0;
            r_rf_addr  <= '0;
            r_rf_we    <= 1'b0;
            r_wb_instr <= '0;
            r_wb_pc    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_src != SRC_IDLE) begin
                r_rf_data  <= w_sel.data;
                r_rf_addr  <= w_sel.addr;
                r_rf_we    <= (w_sel.addr != '0);
                r_wb_instr <= w_sel.instr;
                r_wb_pc    <= w_sel.pc;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rf_write_data_o   = r_rf_data;
    assign rf_write_addr_o   = r_rf_addr;
    assign rf_write_enable_o = r_rf_we;
    assign wb_instruction_o  = r_wb_instr;
    assign wb_pc_o           = r_wb_pc;
    assign overflow_o        = r_overflow;
    assign stall_o           = (w_count != '0);

endmodule
`default_nettype wire
